// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: the decoder's AddrMode
// encoding, the bus-controller FSM states and byte-enable / store-data shaping.
package lsu_pkg;

    // Single source of the decoder's data-memory access mode encoding.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b011,
        LHU = 3'b100,
        SB  = 3'b101,
        SH  = 3'b110,
        SW  = 3'b111
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } access_size_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // LHU shares the top bit with the stores, so it must be excluded explicitly.
    function automatic logic mode_is_store(addr_mode_t m);
        return m[2] && (m != LHU);
    endfunction

    function automatic access_size_t mode_size(addr_mode_t m);
        access_size_t s;
        case (m)
            LB, LBU, SB: s = SizeByte;
            LH, LHU, SH: s = SizeHalf;
            default:     s = SizeWord;
        endcase
        return s;
    endfunction

    // Loads always read the full word; stores enable only the addressed lanes.
    function automatic logic [3:0] mode_be(addr_mode_t m, logic [1:0] off);
        logic [3:0] be;
        if (!mode_is_store(m)) begin
            be = BE_WORD;
        end else begin
            case (mode_size(m))
                SizeByte: be = BE_BYTE << off;
                SizeHalf: be = BE_HALF << {off[1], 1'b0};
                default:  be = BE_WORD;
            endcase
        end
        return be;
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] mode_wdata(addr_mode_t m, logic [31:0] wd);
        logic [31:0] d;
        if (!mode_is_store(m)) begin
            d = 32'h0;
        end else begin
            case (mode_size(m))
                SizeByte: d = {4{wd[7:0]}};
                SizeHalf: d = {2{wd[15:0]}};
                default:  d = wd;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// req/gnt/rvalid data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_bus_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import lsu_pkg::*;

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lsu_load_extend.sv
// Load result shaping: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it according to the access mode.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  addr_mode_t  mode_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension.
    always_comb begin
        byte_sel = 8'h0;
        half_sel = half_sel_word(rdata_i, offset_i[1]);
        result_o = rdata_i;
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (mode_i)
            LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result_o = {24'h0, byte_sel};
            LH:      result_o = {{16{half_sel[15]}}, half_sel};
            LHU:     result_o = {16'h0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

    function automatic logic [15:0] half_sel_word(logic [31:0] w, logic upper);
        return upper ? w[31:16] : w[15:0];
    endfunction

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: runs one data-memory access per mem_en request on a
// req/gnt/rvalid bus and stalls the core until it completes or times out.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the
// bus and complete with a misalign_err pulse.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic [2:0]            addr_mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  bus_err,
    output logic                  misalign_err,
    lsu_bus_ctrl_if.master        bus
);

    // One spare bit so the count can step past the limit on a last-cycle grant.
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state_q;
    addr_mode_t            mode_q;
    logic [1:0]            off_q;
    logic [CntW-1:0]       cnt_q;
    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rdata_valid_q;
    logic                  bus_err_q;
    logic                  misalign_err_q;

    addr_mode_t            mode_in;
    logic                  trap;
    logic                  timeout;
    logic [31:0]           ext_result;

    assign mode_in = addr_mode_t'(addr_mode);
    assign timeout = (cnt_q >= CntLimit);

    lsu_load_extend u_load_extend (
        .rdata_i  (bus.rdata),
        .offset_i (off_q),
        .mode_i   (mode_q),
        .result_o (ext_result)
    );

    // Misalignment detection for the incoming request (constant 0 unless trapping).
    always_comb begin
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (mode_size(mode_in))
            SizeHalf: trap = addr[0];
            SizeWord: trap = |addr[1:0];
            default:  trap = 1'b0;
        endcase
`endif
    end

    // Access FSM with registered bus fields and single-cycle completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mode_q         <= LB;
            off_q          <= 2'b00;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= 4'b0000;
            wdata_q        <= '0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            rdata_valid_q  <= 1'b0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_en) begin
                        mode_q <= mode_in;
                        off_q  <= addr[1:0];
                        cnt_q  <= '0;
                        if (trap) begin
                            rdata_q        <= '0;
                            misalign_err_q <= 1'b1;
                            state_q        <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= mode_is_store(mode_in);
                            addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            be_q    <= mode_be(mode_in, addr[1:0]);
                            wdata_q <= mode_wdata(mode_in, wdata);
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (bus.gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? DONE : WAIT;
                    end else if (timeout) begin
                        req_q     <= 1'b0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (bus.rvalid) begin
                        rdata_q       <= ext_result;
                        rdata_valid_q <= 1'b1;
                        state_q       <= DONE;
                    end else if (timeout) begin
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall        = mem_en && (state_q != DONE);
    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign bus_err      = bus_err_q;
    assign misalign_err = misalign_err_q;

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: a scripted memory responder drives gnt/rvalid,
// expected load results are queued when an access is issued and popped on completion.
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [2:0]  addr_mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    lsu_bus_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    lsu_bus_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .addr_mode    (addr_mode),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .bus_err      (bus_err),
        .misalign_err (misalign_err),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one access from an IDLE cycle through DONE plus one trailing cycle.
    // gnt_dly: REQ-cycle index that receives gnt (<0 = never); rv_dly: cycles after
    // the one following gnt before rvalid (<0 = never).
    task automatic run_access(
        input  logic [2:0]  mode,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  int          gnt_dly,
        input  int          rv_dly,
        input  logic [31:0] rword,
        input  logic        early_rv,
        input  logic        hold_en,
        output int          n_cyc,
        output int          n_stall,
        output int          n_valid,
        output int          n_err,
        output int          n_merr,
        output int          n_req,
        output logic [31:0] got,
        output logic        stable,
        output logic [3:0]  be,
        output logic [31:0] bwd,
        output logic        we,
        output logic [31:0] baddr,
        output logic        req_at_done
    );
        int   gnt_cyc;
        logic done;
        n_cyc = 1; n_valid = 0; n_err = 0; n_merr = 0; n_req = 0;
        got = '0; stable = 1'b1; be = '0; bwd = '0; we = 1'b0; baddr = '0;
        req_at_done = 1'b1; gnt_cyc = -100; done = 1'b0;
        mem_en = 1'b1; addr_mode = mode; addr = a; wdata = wd;
        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0;
        #1;
        n_stall = stall ? 1 : 0;
        while (!done && n_cyc < 100) begin
            cyc();
            n_cyc++;
            if (rdata_valid) n_valid++;
            if (bus_err) n_err++;
            if (misalign_err) n_merr++;
            if (!stall) begin
                done = 1'b1;
                got = rdata;
                req_at_done = bus_if.req;
                bus_if.gnt = 1'b0;
                bus_if.rvalid = 1'b0;
                if (!hold_en) mem_en = 1'b0;
            end else begin
                n_stall++;
                bus_if.gnt = 1'b0;
                bus_if.rvalid = 1'b0;
                bus_if.rdata = $urandom;
                if (rv_dly >= 0 && n_cyc == gnt_cyc + 1 + rv_dly) begin
                    bus_if.rvalid = 1'b1;
                    bus_if.rdata = rword;
                end
                if (bus_if.req) begin
                    if (n_req == 0) begin
                        be = bus_if.be; bwd = bus_if.wdata; we = bus_if.we; baddr = bus_if.addr;
                    end else if (bus_if.be !== be || bus_if.wdata !== bwd ||
                                 bus_if.we !== we || bus_if.addr !== baddr) begin
                        stable = 1'b0;
                    end
                    if (gnt_dly >= 0 && n_req == gnt_dly) begin
                        bus_if.gnt = 1'b1;
                        gnt_cyc = n_cyc;
                        if (early_rv) begin
                            bus_if.rvalid = 1'b1;
                            bus_if.rdata = ~rword;
                        end
                    end
                    n_req++;
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL access_bound: no completion within %0d cycles", n_cyc);
            mem_en = 1'b0;
        end
        cyc();
        if (rdata_valid) n_valid++;
        if (bus_err) n_err++;
        if (misalign_err) n_merr++;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_en = 1'b0; addr_mode = 3'b000; addr = '0; wdata = '0;
        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0;
        repeat (3) cyc();
        total++;
        if ({bus_if.req, bus_if.we, bus_if.be} !== 6'b0) begin
            bad++; $display("FAIL reset_req_we_be got=%b exp=0", {bus_if.req, bus_if.we, bus_if.be});
        end
        total++;
        if ({bus_if.addr, bus_if.wdata, rdata} !== 96'h0) begin
            bad++; $display("FAIL reset_addr_data got=%h exp=0", {bus_if.addr, bus_if.wdata, rdata});
        end
        total++;
        if ({rdata_valid, bus_err, misalign_err, stall} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000",
                            {rdata_valid, bus_err, misalign_err, stall});
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_store();
        typedef struct packed {
            logic [2:0]  mode;
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  be;
            logic [31:0] bwd;
        } st_vec_t;
        st_vec_t tbl [5];
        int nc, ns, nv, ne, nm, nr;
        logic [31:0] got, bwd, baddr;
        logic st, we, rad;
        logic [3:0] be;
        tbl[0] = '{3'b101, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5};
        tbl[1] = '{3'b101, 32'h0000_1001, 32'h1234_563C, 4'b0010, 32'h3C3C_3C3C};
        tbl[2] = '{3'b110, 32'h0000_1002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF};
        tbl[3] = '{3'b110, 32'h0000_1000, 32'h0000_7E01, 4'b0011, 32'h7E01_7E01};
        tbl[4] = '{3'b111, 32'h0000_1008, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF};
        for (int i = 0; i < 5; i++) begin
            run_access(tbl[i].mode, tbl[i].a, tbl[i].wd, 0, -1, 32'h0, 1'b0, 1'b0,
                       nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
            total++;
            if (be !== tbl[i].be) begin
                bad++; $display("FAIL store%0d_be got=%b exp=%b", i, be, tbl[i].be);
            end
            total++;
            if (bwd !== tbl[i].bwd) begin
                bad++; $display("FAIL store%0d_wdata got=%h exp=%h", i, bwd, tbl[i].bwd);
            end
            total++;
            if (we !== 1'b1 || baddr !== {tbl[i].a[31:2], 2'b00}) begin
                bad++; $display("FAIL store%0d_we_addr got=%b/%h exp=1/%h", i, we, baddr,
                                {tbl[i].a[31:2], 2'b00});
            end
            total++;
            if (nc !== 3 || ns !== 2 || nv !== 0 || ne !== 0) begin
                bad++; $display("FAIL store%0d_timing got=cyc%0d stall%0d v%0d e%0d exp=3 2 0 0",
                                i, nc, ns, nv, ne);
            end
        end
    endtask

    task automatic test_load();
        typedef struct packed {
            logic [2:0]  mode;
            logic [31:0] a;
            logic [31:0] word;
            logic [31:0] exp;
            logic        early;
        } ld_vec_t;
        ld_vec_t tbl [8];
        exp_t e;
        int nc, ns, nv, ne, nm, nr;
        logic [31:0] got, bwd, baddr;
        logic st, we, rad;
        logic [3:0] be;
        tbl[0] = '{3'b000, 32'h0000_2002, 32'h12F0_3456, 32'hFFFF_FFF0, 1'b0};
        tbl[1] = '{3'b011, 32'h0000_2002, 32'h12F0_3456, 32'h0000_00F0, 1'b0};
        tbl[2] = '{3'b100, 32'h0000_2002, 32'h8001_ABCD, 32'h0000_8001, 1'b0};
        tbl[3] = '{3'b001, 32'h0000_2002, 32'h8001_ABCD, 32'hFFFF_8001, 1'b0};
        tbl[4] = '{3'b010, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
        tbl[5] = '{3'b000, 32'h0000_2001, 32'h12F0_3456, 32'h0000_0034, 1'b0};
        tbl[6] = '{3'b001, 32'h0000_2000, 32'h8001_ABCD, 32'hFFFF_ABCD, 1'b1};
        tbl[7] = '{3'b011, 32'h0000_2003, 32'h8001_ABCD, 32'h0000_0080, 1'b0};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{tbl[i].exp, 1'b0});
            run_access(tbl[i].mode, tbl[i].a, 32'hFFFF_FFFF, 0, 0, tbl[i].word, tbl[i].early,
                       1'b0, nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
            e = exp_q.pop_front();
            total++;
            if (got !== e.data) begin
                bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, got, e.data);
            end
            total++;
            if (nv !== 1 || ne !== 0) begin
                bad++; $display("FAIL load%0d_pulses got=v%0d e%0d exp=v1 e0", i, nv, ne);
            end
            total++;
            if (nc !== 4 || ns !== 3) begin
                bad++; $display("FAIL load%0d_latency got=cyc%0d stall%0d exp=4 3", i, nc, ns);
            end
            total++;
            if (be !== 4'b1111 || we !== 1'b0 || baddr !== {tbl[i].a[31:2], 2'b00}) begin
                bad++; $display("FAIL load%0d_bus got=%b/%b/%h exp=1111/0/%h", i, be, we, baddr,
                                {tbl[i].a[31:2], 2'b00});
            end
        end
    endtask

    task automatic test_gnt_delay();
        int nc, ns, nv, ne, nm, nr;
        logic [31:0] got, bwd, baddr;
        logic st, we, rad;
        logic [3:0] be;
        run_access(3'b110, 32'h0000_4006, 32'h0000_5AA5, 5, -1, 32'h0, 1'b0, 1'b0,
                   nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
        total++;
        if (st !== 1'b1 || nr !== 6) begin
            bad++; $display("FAIL gnt_delay_stable got=stable%b req%0d exp=1 6", st, nr);
        end
        total++;
        if (be !== 4'b1100 || bwd !== 32'h5AA5_5AA5 || baddr !== 32'h0000_4004) begin
            bad++; $display("FAIL gnt_delay_fields got=%b/%h/%h exp=1100/5aa55aa5/00004004",
                            be, bwd, baddr);
        end
        total++;
        if (nc !== 8 || ns !== 7 || ne !== 0) begin
            bad++; $display("FAIL gnt_delay_timing got=cyc%0d stall%0d e%0d exp=8 7 0", nc, ns, ne);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int nc, ns, nv, ne, nm, nr;
        logic [31:0] got, bwd, baddr;
        logic st, we, rad;
        logic [3:0] be;
        exp_q.push_back('{32'h0, 1'b1});
        run_access(3'b010, 32'h0000_5000, 32'h0, -1, -1, 32'h0, 1'b0, 1'b0,
                   nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
        e = exp_q.pop_front();
        total++;
        if (got !== e.data || (ne == 1) !== e.err) begin
            bad++; $display("FAIL timeout_result got=%h err%0d exp=%h err%b", got, ne, e.data, e.err);
        end
        total++;
        if (nr !== 16 || nc !== 18 || ns !== 17) begin
            bad++; $display("FAIL timeout_cycles got=req%0d cyc%0d stall%0d exp=16 18 17",
                            nr, nc, ns);
        end
        total++;
        if (rad !== 1'b0 || nv !== 0) begin
            bad++; $display("FAIL timeout_req_valid got=req%b v%0d exp=0 0", rad, nv);
        end
        // Whatever arrives late must not be taken; the next load completes normally.
        exp_q.push_back('{32'h0000_00AB, 1'b0});
        run_access(3'b011, 32'h0000_5001, 32'h0, 0, 0, 32'h0000_AB00, 1'b0, 1'b0,
                   nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
        e = exp_q.pop_front();
        total++;
        if (got !== e.data || nc !== 4 || ne !== 0) begin
            bad++; $display("FAIL after_timeout got=%h cyc%0d e%0d exp=%h 4 0", got, nc, ne, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int nc, ns, nv, ne, nm, nr;
        logic [31:0] got, bwd, baddr;
        logic st, we, rad;
        logic [3:0] be;
        exp_q.push_back('{32'h1111_2222, 1'b0});
        run_access(3'b010, 32'h0000_2008, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 1'b1,
                   nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
        e = exp_q.pop_front();
        total++;
        if (got !== e.data || nv !== 1) begin
            bad++; $display("FAIL b2b_first got=%h v%0d exp=%h v1", got, nv, e.data);
        end
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL b2b_idle_stall got=%b exp=1", stall);
        end
        run_access(3'b101, 32'h0000_100A, 32'h0000_0077, 0, -1, 32'h0, 1'b0, 1'b0,
                   nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
        total++;
        if (be !== 4'b0100 || bwd !== 32'h7777_7777 || nc !== 3) begin
            bad++; $display("FAIL b2b_second got=%b/%h cyc%0d exp=0100/77777777 3", be, bwd, nc);
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        mem_en = 1'b1; addr_mode = 3'b010; addr = 32'h0000_2010; wdata = '0;
        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0;
        cyc();
        total++;
        if (bus_if.req !== 1'b1) begin
            bad++; $display("FAIL rst_mid_req got=%b exp=1", bus_if.req);
        end
        bus_if.gnt = 1'b1;
        cyc();
        bus_if.gnt = 1'b0;
        total++;
        if (bus_if.req !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL rst_mid_wait got=req%b stall%b exp=0 1", bus_if.req, stall);
        end
        rst = 1'b1; mem_en = 1'b0;
        cyc();
        rst = 1'b0;
        total++;
        if (bus_if.req !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 32'h0) begin
            bad++; $display("FAIL rst_mid_after got=req%b v%b %h exp=0 0 0",
                            bus_if.req, rdata_valid, rdata);
        end
        nv = 0;
        bus_if.rvalid = 1'b1; bus_if.rdata = 32'h5555_5555;
        repeat (3) begin
            cyc();
            if (rdata_valid) nv++;
        end
        bus_if.rvalid = 1'b0;
        total++;
        if (nv !== 0 || bus_if.req !== 1'b0) begin
            bad++; $display("FAIL rst_mid_stray_rvalid got=v%0d req%b exp=0 0", nv, bus_if.req);
        end
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign();
        int nc, ns, nv, ne, nm, nr;
        logic [31:0] got, bwd, baddr;
        logic st, we, rad;
        logic [3:0] be;
        run_access(3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0,
                   nc, ns, nv, ne, nm, nr, got, st, be, bwd, we, baddr, rad);
        total++;
        if (nr !== 0 || nm !== 1 || nc !== 2 || nv !== 0 || got !== 32'h0) begin
            bad++; $display("FAIL misalign_lw got=req%0d m%0d cyc%0d v%0d %h exp=0 1 2 0 0",
                            nr, nm, nc, nv, got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_gnt_delay();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
